// File: rtl/alioth_wb_pkg.sv
// Shared types and defaults for the write-back unit: result sources, the
// per-source write request bundle, and a small popcount helper.
package alioth_wb_pkg;

  localparam int REG_DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH     = 5;
  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STARVE_W           = 3;

  typedef enum logic [1:0] {
    SRC_ALU1 = 2'd0,
    SRC_ALU2 = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Fairness state for the two long-latency sources (lsu, mdu): a 1-bit
// round-robin pointer and saturating starvation counters.
module wb_rr_arb
  import alioth_wb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic lsu_valid,
  input  logic lsu_ready,
  input  logic mdu_valid,
  input  logic mdu_ready,
  input  logic contended,
  output logic rr,
  output logic lsu_starve,
  output logic mdu_starve
);

  logic [1:0] valid;
  logic [1:0] ready;
  logic [1:0] starve;
  logic       rr_reg;

  assign valid = {mdu_valid, lsu_valid};
  assign ready = {mdu_ready, lsu_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [STARVE_W-1:0] cnt_reg;
      logic [STARVE_W-1:0] cnt_next;

      // Counts cycles of valid-but-not-ready; any handshake or drop of valid restarts it.
      always_comb begin
        if (!valid[gi] || ready[gi]) begin
          cnt_next = '0;
        end else if (cnt_reg == '1) begin
          cnt_next = cnt_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign starve[gi] = (cnt_reg >= STARVE_W'(STARVE_MAX));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg <= 1'b0;
    end else if (contended) begin
      rr_reg <= ~rr_reg;
    end
  end

  assign rr         = rr_reg;
  assign lsu_starve = starve[0];
  assign mdu_starve = starve[1];

endmodule

// File: rtl/wbu.sv
// Write-back unit: merges four result sources onto two registered GPR
// write ports, with ALU port ownership, same-rd collision and lsu/mdu arbitration.
module wbu
  import alioth_wb_pkg::*;
#(
  parameter int DW         = REG_DATA_WIDTH,
  parameter int AW         = REG_ADDR_WIDTH,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          alu1_valid_i,
  output logic          alu1_ready_o,
  input  logic          alu1_we_i,
  input  logic [AW-1:0] alu1_rd_i,
  input  logic [DW-1:0] alu1_wdata_i,

  input  logic          alu2_valid_i,
  output logic          alu2_ready_o,
  input  logic          alu2_we_i,
  input  logic [AW-1:0] alu2_rd_i,
  input  logic [DW-1:0] alu2_wdata_i,

  input  logic          lsu_valid_i,
  output logic          lsu_ready_o,
  input  logic          lsu_we_i,
  input  logic [AW-1:0] lsu_rd_i,
  input  logic [DW-1:0] lsu_wdata_i,

  input  logic          mdu_valid_i,
  output logic          mdu_ready_o,
  input  logic          mdu_we_i,
  input  logic [AW-1:0] mdu_rd_i,
  input  logic [DW-1:0] mdu_wdata_i,

  output logic          we1_o,
  output logic [AW-1:0] waddr1_o,
  output logic [DW-1:0] wdata1_o,
  output logic          we2_o,
  output logic [AW-1:0] waddr2_o,
  output logic [DW-1:0] wdata2_o,
  output logic [2:0]    retire_cnt_o
);

  wb_req_t req [4];

  logic alu1_wr, alu2_wr, alu2_gnt;
  logic lsu_wi, mdu_wi, lsu_req, mdu_req;
  logic lsu_conf, mdu_conf, collision;
  logic p1_free, p2_free;
  logic lsu_p1, lsu_p2, mdu_p1, mdu_p2;
  logic lsu_take, mdu_take, contended;
  logic rr, lsu_starve, mdu_starve, reserve;
  logic use1, use2;
  wb_src_e sel1, sel2;
  logic [3:0] hs;

  wb_req_t    port1_next, port2_next, port1_reg, port2_reg;
  logic [2:0] retire_next, retire_reg;

  assign req[SRC_ALU1] = '{we: alu1_we_i, rd: alu1_rd_i, wdata: alu1_wdata_i};
  assign req[SRC_ALU2] = '{we: alu2_we_i, rd: alu2_rd_i, wdata: alu2_wdata_i};
  assign req[SRC_LSU]  = '{we: lsu_we_i,  rd: lsu_rd_i,  wdata: lsu_wdata_i};
  assign req[SRC_MDU]  = '{we: mdu_we_i,  rd: mdu_rd_i,  wdata: mdu_wdata_i};

  wb_rr_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .lsu_valid  (lsu_valid_i),
    .lsu_ready  (lsu_ready_o),
    .mdu_valid  (mdu_valid_i),
    .mdu_ready  (mdu_ready_o),
    .contended  (contended),
    .rr         (rr),
    .lsu_starve (lsu_starve),
    .mdu_starve (mdu_starve)
  );

  // A starving long-latency source blocks alu2 so port 2 is guaranteed free.
  assign reserve  = lsu_starve | mdu_starve;

  assign alu1_wr  = alu1_valid_i & alu1_we_i & (alu1_rd_i != '0);
  assign alu2_wr  = alu2_valid_i & alu2_we_i & (alu2_rd_i != '0);
  assign alu2_gnt = alu2_wr & ~reserve;

  assign collision = alu1_wr & alu2_gnt & (alu1_rd_i == alu2_rd_i);

  assign lsu_wi   = lsu_we_i & (lsu_rd_i != '0);
  assign mdu_wi   = mdu_we_i & (mdu_rd_i != '0);
  assign lsu_conf = (alu1_wr & (lsu_rd_i == alu1_rd_i)) | (alu2_gnt & (lsu_rd_i == alu2_rd_i));
  assign mdu_conf = (alu1_wr & (mdu_rd_i == alu1_rd_i)) | (alu2_gnt & (mdu_rd_i == alu2_rd_i));
  assign lsu_req  = lsu_valid_i & lsu_wi & ~lsu_conf;
  assign mdu_req  = mdu_valid_i & mdu_wi & ~mdu_conf;

  assign p1_free  = ~alu1_wr;
  assign p2_free  = ~alu2_gnt;

  always_comb begin
    lsu_p1    = 1'b0;
    lsu_p2    = 1'b0;
    mdu_p1    = 1'b0;
    mdu_p2    = 1'b0;
    lsu_take  = 1'b0;
    mdu_take  = 1'b0;
    contended = 1'b0;
    if (reserve && (lsu_starve ? lsu_req : mdu_req)) begin
      if (lsu_starve) begin
        lsu_p2 = 1'b1;
        mdu_p1 = mdu_req & p1_free;
      end else begin
        mdu_p2 = 1'b1;
        lsu_p1 = lsu_req & p1_free;
      end
    end else if (p1_free && p2_free) begin
      lsu_p1 = lsu_req;
      mdu_p1 = mdu_req & ~lsu_req;
      mdu_p2 = mdu_req & lsu_req;
    end else if (p1_free || p2_free) begin
      // Single free port: rr breaks ties, and only a real tie moves the pointer.
      contended = lsu_req & mdu_req;
      lsu_take  = lsu_req & (~mdu_req | ~rr);
      mdu_take  = mdu_req & ~lsu_take;
      lsu_p1    = lsu_take & p1_free;
      lsu_p2    = lsu_take & ~p1_free;
      mdu_p1    = mdu_take & p1_free;
      mdu_p2    = mdu_take & ~p1_free;
    end
  end

  assign alu1_ready_o = ~rst;
  assign alu2_ready_o = ~rst & ~reserve;
  assign lsu_ready_o  = ~rst & (lsu_p1 | lsu_p2 | ~lsu_wi);
  assign mdu_ready_o  = ~rst & (mdu_p1 | mdu_p2 | ~mdu_wi);

  assign hs = {mdu_valid_i & mdu_ready_o, lsu_valid_i & lsu_ready_o,
               alu2_valid_i & alu2_ready_o, alu1_valid_i & alu1_ready_o};
  assign retire_next = popcount4(hs);

  always_comb begin
    use1 = 1'b0;
    sel1 = SRC_ALU1;
    use2 = 1'b0;
    sel2 = SRC_ALU2;
    if (alu1_wr && !collision) begin
      use1 = 1'b1;
      sel1 = SRC_ALU1;
    end else if (lsu_p1) begin
      use1 = 1'b1;
      sel1 = SRC_LSU;
    end else if (mdu_p1) begin
      use1 = 1'b1;
      sel1 = SRC_MDU;
    end
    if (alu2_gnt) begin
      use2 = 1'b1;
      sel2 = SRC_ALU2;
    end else if (lsu_p2) begin
      use2 = 1'b1;
      sel2 = SRC_LSU;
    end else if (mdu_p2) begin
      use2 = 1'b1;
      sel2 = SRC_MDU;
    end
  end

  assign port1_next = use1 ? req[sel1] : '0;
  assign port2_next = use2 ? req[sel2] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port1_reg  <= '0;
      port2_reg  <= '0;
      retire_reg <= '0;
    end else begin
      port1_reg  <= port1_next;
      port2_reg  <= port2_next;
      retire_reg <= retire_next;
    end
  end

  assign we1_o        = port1_reg.we;
  assign waddr1_o     = port1_reg.rd;
  assign wdata1_o     = port1_reg.wdata;
  assign we2_o        = port2_reg.we;
  assign waddr2_o     = port2_reg.rd;
  assign wdata2_o     = port2_reg.wdata;
  assign retire_cnt_o = retire_reg;

endmodule
